ulaw_argmax: RTL and testbench

ULAW_ARGMAX -- requirements
Module: ulaw_argmax

---
 rtl/ulaw_argmax.sv | 157 +++++++++++++++
 tb/tb_ulaw_argmax.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ulaw_argmax.sv
// Sequential argmax over NUM_CLASSES u-law scores, one compare per clock.
// Optional hit tracking (hit / hit_count) is built only when ULAW_ARGMAX_HIT_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; results from the last scan are held
// SCAN  | comparing scores[ptr] against the running best, one per cycle
// DONE  | one-cycle result pulse
module ulaw_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_CLASSES-1:0][7:0]  scores,
  input  logic [3:0]                   exp_y,
  input  logic                         clr,
  output logic                         busy,
  output logic                         done,
  output logic [3:0]                   class_idx,
  output logic [7:0]                   max_val,
  output logic                         hit,
  output logic [CNT_WIDTH-1:0]         hit_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_PTR = 4'(NUM_CLASSES - 1);

  state_t state, state_nxt;

  logic [NUM_CLASSES-1:0][7:0] scores_q;
  logic [3:0] ptr;
  logic [3:0] best_idx;
  logic [7:0] best_val;
  logic [3:0] class_idx_q;
  logic [7:0] max_val_q;

  logic [7:0] cand;
  logic       better;
  logic [3:0] win_idx;
  logic [7:0] win_val;
  logic       last_cmp;

  // Map a u-law code onto an unsigned rank: positives above negatives, and
  // for negatives a smaller magnitude ranks higher.
  function automatic logic [7:0] rank(input logic [7:0] code);
    logic [7:0] t;
    t = ~code;
    if (t[7]) rank = {1'b0, ~t[6:0]};
    else      rank = {1'b1,  t[6:0]};
  endfunction

  always_comb begin
    cand = scores_q[0];
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (ptr == 4'(i)) cand = scores_q[i];
    end
    // strict compare so ties keep the earlier (lower) index
    better   = rank(cand) > rank(best_val);
    win_idx  = better ? (ptr + 4'd1) : best_idx;
    win_val  = better ? cand : best_val;
    last_cmp = (state == SCAN) && (ptr == LAST_PTR);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = SCAN;
      SCAN:    if (last_cmp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scores_q    <= '0;
      ptr         <= 4'd0;
      best_idx    <= 4'd0;
      best_val    <= 8'd0;
      class_idx_q <= 4'd0;
      max_val_q   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            scores_q <= scores;
            best_val <= scores[0];
            best_idx <= 4'd1;
            ptr      <= 4'd1;
          end
        end
        SCAN: begin
          best_val <= win_val;
          best_idx <= win_idx;
          ptr      <= ptr + 4'd1;
          if (last_cmp) begin
            class_idx_q <= win_idx;
            max_val_q   <= win_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == SCAN);
  assign done      = (state == DONE);
  assign class_idx = class_idx_q;
  assign max_val   = max_val_q;

`ifdef ULAW_ARGMAX_HIT_CNT_EN
  logic [3:0]           exp_q;
  logic                 hit_q;
  logic [CNT_WIDTH-1:0] hit_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= 4'd0;
      hit_q <= 1'b0;
    end else begin
      if (state == IDLE && start) exp_q <= exp_y;
      if (last_cmp)               hit_q <= (win_idx == exp_q);
    end
  end

  // Counter advances at the end of the DONE cycle, so a clr seen during DONE wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q <= '0;
    end else if (clr) begin
      hit_count_q <= '0;
    end else if (state == DONE && hit_q && hit_count_q != '1) begin
      hit_count_q <= hit_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign hit       = hit_q;
  assign hit_count = hit_count_q;
`else
  logic unused_hit_inputs;
  assign unused_hit_inputs = ^{exp_y, clr};
  assign hit       = 1'b0;
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_ulaw_argmax.sv
// Scoreboard bench for ulaw_argmax: directed score sets, expected results queued at start,
// a negedge monitor pops and compares on every done.
module tb_ulaw_argmax;
  localparam int N  = 10;
  localparam int CW = 16;

`ifdef ULAW_ARGMAX_HIT_CNT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst, start, clr;
  logic [N-1:0][7:0]   scores;
  logic [3:0]          exp_y;
  logic                busy, done, hit;
  logic [3:0]          class_idx;
  logic [7:0]          max_val;
  logic [CW-1:0]       hit_count;

  ulaw_argmax #(.NUM_CLASSES(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .scores(scores), .exp_y(exp_y), .clr(clr),
    .busy(busy), .done(done), .class_idx(class_idx), .max_val(max_val),
    .hit(hit), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] val;
    logic       hit;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no done");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("class_idx", 32'(class_idx), 32'(e.idx));
        check("max_val",   32'(max_val),   32'(e.val));
        check("hit",       32'(hit),       32'(e.hit));
      end
    end
  end

  // Queue the expected result, then present start for exactly one clock.
  task automatic launch(input logic [N-1:0][7:0] s, input logic [3:0] ey,
                        input logic [3:0] eidx, input logic [7:0] eval);
    exp_t e;
    e.idx = eidx;
    e.val = eval;
    e.hit = HIT_EN && (eidx == ey);
    sb.push_back(e);
    scores = s;
    exp_y  = ey;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Called at the negedge right after the start edge; returns at the negedge where done is high.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin
        edges = k + 1;
        return;
      end
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done in 40 cycles, expected done");
  endtask

  task automatic run(input logic [N-1:0][7:0] s, input logic [3:0] ey,
                     input logic [3:0] eidx, input logic [7:0] eval, input bit clr_at_done);
    int edges, bc;
    launch(s, ey, eidx, eval);
    wait_done(edges, bc);
    check("done_edges",  32'(edges), 32'(N));
    check("busy_cycles", 32'(bc),    32'(N - 1));
    if (clr_at_done) clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  logic [N-1:0][7:0] s;
  int edges, bc, extra;

  initial begin
    rst = 1'b1; start = 1'b0; clr = 1'b0; scores = '0; exp_y = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_class_idx", 32'(class_idx), 32'd0);
    check("rst_max_val",   32'(max_val),   32'd0);
    check("rst_hit",       32'(hit),       32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    @(negedge clk);

    // single positive maximum in the middle
    for (int i = 0; i < N; i++) s[i] = 8'hFF;
    s[6] = 8'h80;
    run(s, 4'd7, 4'd7, 8'h80, 1'b0);

    // all equal: first index wins
    for (int i = 0; i < N; i++) s[i] = 8'hFF;
    run(s, 4'd2, 4'd1, 8'hFF, 1'b0);

    // all negative: smallest magnitude wins
    for (int i = 0; i < N; i++) s[i] = 8'h01;
    s[0] = 8'h00;
    s[3] = 8'h7F;
    run(s, 4'd4, 4'd4, 8'h7F, 1'b0);

    // second start during scan ignored; inputs change mid-scan
    for (int i = 0; i < N; i++) s[i] = 8'hFF;
    s[2] = 8'h90;
    launch(s, 4'd3, 4'd3, 8'h90);
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) s[i] = 8'hFF;
    s[8] = 8'h80;
    scores = s;
    exp_y  = 4'd9;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(edges, bc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", 32'(busy), 32'd0);
    repeat (15) @(negedge clk);
    check("hit_count_3", 32'(hit_count), HIT_EN ? 32'd3 : 32'd0);

    // reset during scan aborts without a done
    for (int i = 0; i < N; i++) s[i] = 8'hFF;
    s[5] = 8'h80;
    scores = s;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_class_idx", 32'(class_idx), 32'd0);
    check("abort_max_val",   32'(max_val),   32'd0);
    check("abort_hit",       32'(hit),       32'd0);
    check("abort_hit_count", 32'(hit_count), 32'd0);
    extra = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("abort_no_done", 32'(extra), 32'd0);

    // rst wins over start in the same cycle
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_over_start", 32'(busy), 32'd0);

    // last index wins, with a tie lower down
    for (int i = 0; i < N; i++) s[i] = 8'h00;
    s[4] = 8'h85;
    s[7] = 8'h85;
    s[9] = 8'h81;
    run(s, 4'd10, 4'd10, 8'h81, 1'b0);
    @(negedge clk);
    check("hit_count_after_rst", 32'(hit_count), HIT_EN ? 32'd1 : 32'd0);

    // tie between two positives: lower index kept; clr coincides with a hit done
    s[9] = 8'h00;
    run(s, 4'd5, 4'd5, 8'h85, 1'b1);
    @(negedge clk);
    check("clr_with_hit_done", 32'(hit_count), 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
